memoria_bytes: RTL
==================

# memoria_bytes

Parametrised, synchronous, word-organised data/instruction memory for the single-cycle/multi-cycle MIPS core, mapped at a configurable base address (default 0x00400000). Next generation of the core's memory: registered read, programmable access latency with a ready/valid handshake, byte-lane writes, and explicit error reporting for out-of-range or misaligned addresses. Sits between the core's memory-stage control (`mem_rd`/`mem_wd`) and the register file write-back path.

## Interface
- `DATA_W`, 32, word width in bits; must be a multiple of 8.
- `DEPTH`, 64, number of words.
- `BASE_ADDR`, 32'h00400000, byte address of word 0.
- `LAT`, 1, access latency in cycles (≥1) from accept to response.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `dir`  in  32  byte address; sampled on accept.
- `data_input`  in  DATA_W  write data; sampled on accept.
- `byte_en`  in  DATA_W/8  write lane enables; sampled on accept.
- `mem_rd`  in  1  read request.
- `mem_wd`  in  1  write request.
- `ready`  out  1  high when a request can be accepted.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_err`  out  1  qualifies `resp_valid`: access rejected.
- `data_output`  out  DATA_W  read data, valid with `resp_valid`.

## Operation
- Index = (`dir` − `BASE_ADDR`) >> 2 (for DATA_W=32; generally >> log2(DATA_W/8)), computed in 32 bits.
- Error if `dir` < `BASE_ADDR`, index ≥ `DEPTH`, low address bits ≠ 0, or `mem_rd` and `mem_wd` both high. On error: no array write, `data_output` = 0, `resp_err` = 1.
- FSM: IDLE → (accept) → WAIT → RESP → IDLE.
  - IDLE: `ready`=1. Accept when `mem_rd` | `mem_wd`; latch address, data, lanes, op, error flag; load counter = `LAT`−1.
  - WAIT: counter decrements each cycle; leave when counter = 0 (with `LAT`=1, WAIT lasts one cycle).
  - On leaving WAIT: perform write (lanes per `byte_en`) or capture read word into output register; go to RESP.
  - RESP: `resp_valid`=1 one cycle; return to IDLE.
- Requests while `ready`=0 are ignored (requester must hold until accepted).
- Read in RESP of a word written by the immediately preceding access returns the new value.
- Array initialised to zero at time 0; `rst` does not clear the array.

## Timing
- Accept at edge k; `resp_valid` high in the cycle following edge k+`LAT`; `ready` low from edge k until edge k+`LAT`+1.
- Throughput: one access per `LAT`+2 cycles.
- Reset values: `ready`=1, `resp_valid`=0, `resp_err`=0, `data_output`=0, FSM=IDLE, counter=0.
- `rst` mid-access: transaction dropped, no write performed if reset precedes the write edge, no response issued.
- `data_output` holds its last value between responses.

## Configuration
- `MEMORIA_BYTE_WRITE_EN` defined: writes update only lanes with `byte_en` set; `byte_en`=0 is a legal no-op write (response without error).
- Undefined: `byte_en` ignored; every write updates the full word.

## Structure
- Shared package: FSM state enumeration (IDLE/WAIT/RESP), default `BASE_ADDR`, helper constant for lane count (`DATA_W`/8).
- One sub-module: `memoria_addr_check` — combinational index computation and error decode (range, alignment, dual-op).

## Test plan
- Reset then write 0x00853022 to 0x00400018, read 0x00400018 (`LAT`=1) -> `resp_valid` two cycles after each accept, read data 0x00853022, `resp_err`=0.
- Read 0x003FFFFC and 0x00400100 (`DEPTH`=64) -> `resp_err`=1, `data_output`=0, array unchanged.
- Read 0x00400002 -> `resp_err`=1; `mem_rd`=`mem_wd`=1 at 0x00400004 -> `resp_err`=1, word 1 unchanged.
- With `MEMORIA_BYTE_WRITE_EN`: word 0x11223344, write 0xAABBCCDD `byte_en`=4'b0101 -> read 0x11BB33DD; without macro -> 0xAABBCCDD.
- `LAT`=4: accept at edge k -> `ready` low edges k..k+4, `resp_valid` only in cycle after edge k+4; requests during busy ignored.
- Assert `rst` during WAIT of a write -> no response, target word retains old value, `ready`=1 after reset edge.

Source files
------------

// File: rtl/memoria_bytes_pkg.sv
// Shared types and constants for the memoria_bytes word memory.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: FSM state encoding, default base address, lane-count helper.
package memoria_bytes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte address of word 0 in the MIPS user text/data segment.
  localparam logic [31:0] MEM_BASE_ADDR_DEFAULT = 32'h0040_0000;

  // Number of byte lanes in a word of the given width.
  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/memoria_addr_check.sv
// Address decode: byte address to word index plus access-error flag.
// Latency: combinational, zero cycles.
// Backpressure: none; evaluated on whatever address/op is presented.
//
// Ports:
//   dir            byte address of the request
//   mem_rd/mem_wd  requested operation (both high is an error)
//   idx            word index into the array (valid only when err = 0)
//   err            below base, beyond DEPTH, misaligned, or dual-op
module memoria_addr_check
  import memoria_bytes_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = MEM_BASE_ADDR_DEFAULT,
  parameter int          AW        = 6
) (
  input  logic [31:0]   dir,
  input  logic          mem_rd,
  input  logic          mem_wd,
  output logic [AW-1:0] idx,
  output logic          err
);

  localparam int          SHIFT      = $clog2(lane_count(DATA_W));
  localparam logic [31:0] ALIGN_MASK = 32'((64'd1 << SHIFT) - 64'd1);

  logic [31:0] offset;
  logic [31:0] word_idx;
  logic        below;
  logic        out_of_range;
  logic        misaligned;
  logic        dual_op;

  always_comb begin
    offset       = dir - BASE_ADDR;
    word_idx     = offset >> SHIFT;
    // The subtraction wraps for addresses under the base, so that case is
    // flagged on its own rather than relying on the range compare.
    below        = (dir < BASE_ADDR);
    out_of_range = (word_idx >= 32'(DEPTH));
    misaligned   = ((dir & ALIGN_MASK) != 32'd0);
    dual_op      = mem_rd & mem_wd;
    err          = below | out_of_range | misaligned | dual_op;
    idx          = word_idx[AW-1:0];
  end

endmodule

// File: rtl/memoria_bytes.sv
// Word-organised data/instruction memory with registered read and error reporting.
// Latency: accept at edge k, resp_valid in the cycle after edge k+LAT.
// Backpressure: ready low while busy; requests seen with ready=0 are ignored.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   dir               byte address, sampled on accept
//   data_input        write data, sampled on accept
//   byte_en           write lane enables, sampled on accept
//   mem_rd / mem_wd   read / write request
//   ready             request can be accepted this cycle
//   resp_valid        one-cycle response pulse
//   resp_err          with resp_valid: access rejected, no array change
//   data_output       read data (0 on error), holds between responses
// Build option: MEMORIA_BYTE_WRITE_EN enables per-lane writes via byte_en;
// without it every write replaces the full word.
module memoria_bytes
  import memoria_bytes_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = MEM_BASE_ADDR_DEFAULT,
  parameter int          LAT       = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   dir,
  input  logic [DATA_W-1:0]             data_input,
  input  logic [lane_count(DATA_W)-1:0] byte_en,
  input  logic                          mem_rd,
  input  logic                          mem_wd,
  output logic                          ready,
  output logic                          resp_valid,
  output logic                          resp_err,
  output logic [DATA_W-1:0]             data_output
);

  localparam int LANES = lane_count(DATA_W);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = (LAT > 1) ? $clog2(LAT) : 1;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     cnt;
  logic [AW-1:0]     idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic              err_q;
  logic [LANES-1:0]  lane_we;
  logic [AW-1:0]     chk_idx;
  logic              chk_err;
  logic              accept;
  logic              finish;

  // Zero at time 0; reset deliberately leaves contents untouched.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  memoria_addr_check #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR),
    .AW        (AW)
  ) u_addr_check (
    .dir    (dir),
    .mem_rd (mem_rd),
    .mem_wd (mem_wd),
    .idx    (chk_idx),
    .err    (chk_err)
  );

`ifdef MEMORIA_BYTE_WRITE_EN
  logic [LANES-1:0] be_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      be_q <= '0;
    end else if (accept) begin
      be_q <= byte_en;
    end
  end

  assign lane_we = be_q;
`else
  logic unused_byte_en;

  assign unused_byte_en = ^byte_en;
  assign lane_we        = '1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (mem_rd | mem_wd) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // The access itself happens on the edge that leaves WAIT.
        if (cnt == '0) begin
          finish    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      data_output <= '0;
    end else begin
      if (accept) begin
        cnt     <= CW'(LAT - 1);
        idx_q   <= chk_idx;
        wdata_q <= data_input;
        wr_q    <= mem_wd;
        err_q   <= chk_err;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      // Successful writes leave the last read value on data_output.
      if (finish) begin
        if (err_q) begin
          data_output <= '0;
        end else if (!wr_q) begin
          data_output <= mem[idx_q];
        end
      end
    end
  end

  // Gated by !rst so a reset landing on the write edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst && finish && wr_q && !err_q) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_we[l]) begin
          mem[idx_q][8*l +: 8] <= wdata_q[8*l +: 8];
        end
      end
    end
  end

endmodule
